// File: rtl/block_memory_responder_if.sv
// ---------------------------------------------------------------------------
// block_memory_responder_if
//
// Word-serial memory bus between the cache controller and the main-memory
// responder. One word request at a time: the cache holds MReq/MWE/MAddr/MWData
// stable until the responder pulses MReady for one cycle.
//
// Signals:
//   MReq    cache -> mem   word request valid, held until MReady
//   MWE     cache -> mem   1 = write, 0 = read
//   MAddr   cache -> mem   30-bit word address ([1:0] = offset in block)
//   MWData  cache -> mem   write data
//   MReady  mem -> cache   one-cycle completion pulse
//   MRData  mem -> cache   read data, valid with MReady of a read and held
//   Busy    mem -> cache   responder is working on a request
//
// Modports:
//   master  cache controller side
//   slave   memory responder side
// ---------------------------------------------------------------------------
interface block_memory_responder_if;
  logic        MReq;
  logic        MWE;
  logic [29:0] MAddr;
  logic [31:0] MWData;
  logic        MReady;
  logic [31:0] MRData;
  logic        Busy;

  modport master (
    output MReq,
    output MWE,
    output MAddr,
    output MWData,
    input  MReady,
    input  MRData,
    input  Busy
  );

  modport slave (
    input  MReq,
    input  MWE,
    input  MAddr,
    input  MWData,
    output MReady,
    output MRData,
    output Busy
  );
endinterface

// File: rtl/block_memory_responder.sv
// ---------------------------------------------------------------------------
// block_memory_responder
//
// Main-memory model for the cache's word-serial refill / write-back protocol.
// Each request is completed against an internal word array after a latency
// that depends on whether the word continues the previous access sequentially
// within the same 4-word block (BURST_LAT) or not (FIRST_LAT).
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 32-bit words (>= 2)
//   FIRST_LAT   acceptance-to-MReady cycles for a non-sequential word (>= 1)
//   BURST_LAT   acceptance-to-MReady cycles for a sequential word (>= 1)
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   Reset    synchronous active-high reset
//   mem_bus  slave side of the cache/memory bus (see block_memory_responder_if)
// ---------------------------------------------------------------------------
module block_memory_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int FIRST_LAT  = 4,
  parameter int BURST_LAT  = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  block_memory_responder_if.slave  mem_bus
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (FIRST_LAT > BURST_LAT) ? FIRST_LAT : BURST_LAT;
  // The counter holds L-2 at most, so clog2(MAX_LAT) bits are always enough.
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  // Counter preload for each latency class. A latency of L cycles spends one
  // cycle in IDLE (acceptance), L-1 cycles in WAIT, then ACK; so WAIT starts
  // with L-2 and leaves when the counter reads zero.
  localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'((FIRST_LAT >= 2) ? FIRST_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'((BURST_LAT >= 2) ? BURST_LAT - 2 : 0);
  localparam bit               FIRST_ONE = (FIRST_LAT == 1);
  localparam bit               BURST_ONE = (BURST_LAT == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Request captured at acceptance; the cache must hold it unchanged.
  logic [29:0]             addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;

  // Record of the last completed word, used only for latency selection.
  logic                    burst_valid_q, burst_valid_d;
  logic [27:0]             last_blk_q, last_blk_d;
  logic [1:0]              last_off_q, last_off_d;
  logic                    last_we_q, last_we_d;

  // Word array and its registered read port.
  logic [31:0]             mem_q [DEPTH];
  logic [31:0]             rdata_q;
  logic                    rd_en;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   wr_idx;

  // Decodes of the incoming request.
  logic                    seq;
  logic                    abort;

  // -------------------------------------------------------------------------
  // Request classification
  // -------------------------------------------------------------------------
  // A word is sequential when it is the next offset inside the same block as
  // the last completed word, in the same direction, with no idle gap between
  // them (burst_valid is dropped by any idle cycle). Offset 3 -> 0 would cross
  // into the next block and is therefore not sequential.
  always_comb begin
    seq = burst_valid_q
       && (mem_bus.MAddr[29:2] == last_blk_q)
       && (last_off_q != 2'd3)
       && (mem_bus.MAddr[1:0] == (last_off_q + 2'd1))
       && (mem_bus.MWE == last_we_q);
  end

  // While waiting, any withdrawal or change of the request cancels it.
  always_comb begin
    abort = !mem_bus.MReq
         || (mem_bus.MAddr != addr_q)
         || (mem_bus.MWE != we_q);
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    burst_valid_d = burst_valid_q;
    last_blk_d    = last_blk_q;
    last_off_d    = last_off_q;
    last_we_d     = last_we_q;
    rd_en         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!mem_bus.MReq) begin
          // An idle cycle breaks any burst in progress.
          burst_valid_d = 1'b0;
        end else begin
          addr_d  = mem_bus.MAddr;
          we_d    = mem_bus.MWE;
          wdata_d = mem_bus.MWData;
          if (seq ? BURST_ONE : FIRST_ONE) begin
            // Single-cycle latency: straight to ACK, so the read port must
            // fire on this same edge to have data ready in the ACK cycle.
            state_d = S_ACK;
            rd_en   = !mem_bus.MWE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = seq ? BURST_CNT : FIRST_CNT;
          end
        end
      end

      S_WAIT: begin
        // Abort is checked first so it wins over a simultaneous expiry.
        if (abort) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          burst_valid_d = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          rd_en   = !we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ACK: begin
        // MReq is not looked at here; the cache only moves on after MReady.
        state_d       = S_IDLE;
        burst_valid_d = 1'b1;
        last_blk_d    = addr_q[29:2];
        last_off_d    = addr_q[1:0];
        last_we_d     = we_q;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // The address that ends up latched is the one the data belongs to.
    rd_idx = addr_d[DEPTH_LOG2-1:0];
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      burst_valid_q <= 1'b0;
      last_blk_q    <= '0;
      last_off_q    <= '0;
      last_we_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      burst_valid_q <= burst_valid_d;
      last_blk_q    <= last_blk_d;
      last_off_q    <= last_off_d;
      last_we_q     <= last_we_d;
    end
  end

  // -------------------------------------------------------------------------
  // Word array
  // -------------------------------------------------------------------------
  // Writes land at the end of the ACK cycle, so a read accepted in the
  // following IDLE cycle already sees the new word. A write whose ACK edge
  // coincides with Reset is dropped. The array itself is never cleared.
  assign wr_en  = (state_q == S_ACK) && we_q && !Reset;
  assign wr_idx = addr_q[DEPTH_LOG2-1:0];

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wdata_q;
    end
  end

  // Registered read port: loaded only on the edge entering ACK for a read,
  // so MRData keeps its value across writes, aborts and idle time.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[rd_idx];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_bus.MReady = (state_q == S_ACK);
  assign mem_bus.MRData = rdata_q;
  assign mem_bus.Busy   = (state_q != S_IDLE);

endmodule
